// File: rtl/prom_pkg.sv
// Shared definitions for the PROM lookup pipeline: default widths, the
// legacy prom2 output-0 function and the per-entry reset image.
package prom_pkg;

  localparam int PROM_ADDR_W     = 9;
  localparam int PROM_DATA_W     = 8;
  // Widest entry the reset-image helper can describe. Callers keep the low
  // DATA_W bits, so any DATA_W up to this width is supported.
  localparam int PROM_MAX_DATA_W = 64;

  // Legacy prom2 output-0 cone. Only a[7:0] matter; a[6] is don't-care.
  function automatic logic f0(input logic [7:0] a);
    if (a[0]) begin
      return ~a[1] & ~a[2] & ~a[3];
    end
    return ~(~a[1] & ~a[2] & ~a[3] & ~a[4] & ~a[5] & ~a[7]);
  endfunction

  // Reset contents of one entry: bit 0 optionally carries f0, all other
  // bits are zero.
  function automatic logic [PROM_MAX_DATA_W-1:0] init_entry(input logic [7:0] a,
                                                            input logic reset_f0);
    logic [PROM_MAX_DATA_W-1:0] w;
    w    = '0;
    w[0] = reset_f0 & f0(a);
    return w;
  endfunction

endpackage

// File: rtl/prom_lookup_pipe_if.sv
// Bus bundle for prom_lookup_pipe: read request channel, read response
// channel, program write port and lock control.
//
// Handshake: a channel transfers on a rising edge where valid && ready are
// both high. The producer must keep valid and its payload stable until the
// transfer; ready may change freely and is allowed to depend on valid.
interface prom_lookup_pipe_if
  import prom_pkg::*;
#(
  parameter int ADDR_W = PROM_ADDR_W,
  parameter int DATA_W = PROM_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              prog_lock;
  logic              locked;

  // Requester / programmer side.
  modport master (
    output in_valid, in_addr, out_ready, wr_en, wr_addr, wr_data, prog_lock,
    input  in_ready, out_valid, out_data, locked
  );

  // PROM side.
  modport slave (
    input  in_valid, in_addr, out_ready, wr_en, wr_addr, wr_data, prog_lock,
    output in_ready, out_valid, out_data, locked
  );
endinterface

// File: rtl/prom_store.sv
// PROM storage array: async-reset initialisation to the legacy image, a
// write port gated by the lock, and a combinational read port.
// Build option: PROM_WR_BYPASS_EN makes a same-cycle write to the address
// being read visible on the read port (write-first); otherwise read-first.
module prom_store
  import prom_pkg::*;
#(
  parameter int ADDR_W   = PROM_ADDR_W,
  parameter int DATA_W   = PROM_DATA_W,
  parameter int RESET_F0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              locked,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] rst_img [DEPTH];
  logic              wr_ok;

  assign wr_ok = wr_en && !locked;

  // Constant per-entry reset image; a[8+] do not influence f0.
  for (genvar i = 0; i < DEPTH; i++) begin : g_init
    localparam logic [PROM_MAX_DATA_W-1:0] INIT = init_entry(8'(i), RESET_F0 != 0);
    assign rst_img[i] = INIT[DATA_W-1:0];
  end

  // Storage: revert to the reset image on rst_n, otherwise take unlocked writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= rst_img[i];
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port, with optional forwarding of a coincident write.
  always_comb begin
    rd_data = mem[rd_addr];
`ifdef PROM_WR_BYPASS_EN
    if (wr_ok && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
`endif
  end

endmodule

// File: rtl/prom_lookup_pipe.sv
// Registered PROM lookup with a two-stage valid/ready read pipeline
// (fixed 2-cycle latency, 1 read/clk) and a sticky program lock.
// S1 holds the accepted address, S2 holds the looked-up data.
// ADDR_W must be at least 8 since the reset image uses a[7].
// Build option: PROM_WR_BYPASS_EN (see prom_store) selects write-first
// behaviour when a write hits the address moving from S1 to S2.
module prom_lookup_pipe
  import prom_pkg::*;
#(
  parameter int ADDR_W   = PROM_ADDR_W,
  parameter int DATA_W   = PROM_DATA_W,
  parameter int RESET_F0 = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  prom_lookup_pipe_if.slave   bus
);

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              locked_q;
  logic [DATA_W-1:0] rd_data;
  logic              adv2;
  logic              in_ready;
  logic              accept;

  // S1 moves into S2 whenever S2 is empty or being drained this cycle.
  assign adv2     = s1_valid && (!out_valid_q || bus.out_ready);
  assign in_ready = !s1_valid || adv2;
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.locked    = locked_q;

  prom_store #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_F0 (RESET_F0)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .locked  (locked_q),
    .rd_addr (s1_addr),
    .rd_data (rd_data)
  );

  // S1: capture the request address on accept, empty when it moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_addr  <= bus.in_addr;
    end else if (adv2) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: load looked-up data on advance; data holds while stalled or idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (adv2) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rd_data;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky lock: set by a prog_lock pulse, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q <= 1'b0;
    end else if (bus.prog_lock) begin
      locked_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prom_lookup_pipe.sv
// Directed bench for prom_lookup_pipe: reset image, streaming latency,
// backpressure, write/read collision, program lock and mid-stream reset.
module tb_prom_lookup_pipe;
  import prom_pkg::*;

  localparam int AW = 9;
  localparam int DW = 8;

`ifdef PROM_WR_BYPASS_EN
  localparam logic [DW-1:0] COLL_EXP = 8'hC3;
`else
  localparam logic [DW-1:0] COLL_EXP = 8'h01;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  prom_lookup_pipe_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prom_lookup_pipe #(.ADDR_W(AW), .DATA_W(DW), .RESET_F0(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Output monitor: compares every completed response against exp_q.
  always @(negedge clk) begin
    #3;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(bus.out_data), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", 32'(bus.out_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Present a request at a negedge and hold it until accepted.
  task automatic send(input logic [AW-1:0] a);
    logic ok;
    int   guard;
    ok           = 1'b0;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_addr  = a;
    while (!ok && guard < 50) begin
      #4 ok = bus.in_ready;
      @(negedge clk);
      guard++;
    end
    check("send_accept", 32'(ok), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    exp_q.push_back(e);
    send(a);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 0);
    check("drain_idle", 32'(bus.out_valid), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.out_ready = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.prog_lock = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_locked", 32'(bus.locked), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_data", 32'(bus.out_data), 0);
    check("post_rst_ready", 32'(bus.in_ready), 1);

    // Reset image, back-to-back reads, 2-cycle latency.
    fork
      begin
        read(9'h001, 8'h01);
        read(9'h003, 8'h00);
        read(9'h000, 8'h00);
        read(9'h080, 8'h01);
      end
      begin
        @(negedge clk);
        check("t1_latency", 32'(bus.out_valid), 0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("t1_stream", 32'(bus.out_valid), 1);
        end
        @(negedge clk);
        check("t1_idle", 32'(bus.out_valid), 0);
      end
    join
    check("t1_all_seen", 32'(exp_q.size()), 0);

    // Backpressure: hold out_ready low for 5 cycles while streaming.
    bus.out_ready = 1'b0;
    fork
      begin
        read(9'h001, 8'h01);
        read(9'h002, 8'h01);
        read(9'h003, 8'h00);
        read(9'h004, 8'h01);
      end
      begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("bp_valid_hold", 32'(bus.out_valid), 1);
          check("bp_data_hold", 32'(bus.out_data), 32'h01);
          #1 check("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_no_gap", 32'(bus.out_valid), 1);
        end
        @(negedge clk);
        check("bp_done", 32'(bus.out_valid), 0);
      end
    join
    check("bp_all_seen", 32'(exp_q.size()), 0);

    // Collision: write to the S1 address in the cycle it moves to S2.
    exp_q.push_back(COLL_EXP);
    bus.in_valid = 1'b1;
    bus.in_addr  = 9'h010;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 9'h010;
    bus.wr_data  = 8'hC3;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("coll_valid", 32'(bus.out_valid), 1);
    check("coll_data", 32'(bus.out_data), 32'(COLL_EXP));
    drain();
    read(9'h010, 8'hC3);
    drain();

    // Program, lock (write in the lock cycle still lands), then try rewriting.
    wr(9'h0AB, 8'h5A);
    bus.prog_lock = 1'b1;
    wr(9'h0AC, 8'h33);
    bus.prog_lock = 1'b0;
    check("locked_set", 32'(bus.locked), 1);
    wr(9'h0AB, 8'hFF);
    wr(9'h0AC, 8'h00);
    read(9'h0AB, 8'h5A);
    read(9'h0AC, 8'h33);
    drain();
    check("locked_sticky", 32'(bus.locked), 1);

    // Asynchronous reset with two requests in flight.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_addr   = 9'h001;
    @(negedge clk);
    bus.in_addr   = 9'h002;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    check("inflight_valid", 32'(bus.out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 0);
    check("arst_locked", 32'(bus.locked), 0);
    check("arst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_stale", 32'(bus.out_valid), 0);
    end
    read(9'h0AB, 8'h00);
    read(9'h0AC, 8'h01);
    drain();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
